// File: rtl/ul_spectrum_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ul_spectrum_reader_pkg
// Brief    : Shared state encoding, sync words and defaults for the reader.
// Revision : 1.0 - initial release
// ============================================================================
package ul_spectrum_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] c_SYNC_HI        = 16'h7FFF;
    localparam logic [15:0] c_SYNC_LO        = 16'h8000;
    localparam int          c_DEFAULT_N_BINS = 1024;
    localparam int          c_DEFAULT_RD_LAT = 2;

    function automatic logic [10:0] clamp_nbins(input logic [10:0] req,
                                                input logic [10:0] max_bins);
        return ((req == 11'd0) || (req > max_bins)) ? max_bins : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ul_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ul_rd_pipe
// Brief    : DEPTH-deep valid/sof/eof shift register matching RAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module ul_rd_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  logic sof_i,
    input  logic eof_i,
    output logic valid_o,
    output logic sof_o,
    output logic eof_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign valid_o = valid_i;
            assign sof_o   = sof_i;
            assign eof_o   = eof_i;
        end else begin : g_shift
            logic [DEPTH-1:0] r_valid;
            logic [DEPTH-1:0] r_sof;
            logic [DEPTH-1:0] r_eof;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_valid <= '0;
                    r_sof   <= '0;
                    r_eof   <= '0;
                end else begin
                    r_valid[0] <= valid_i;
                    r_sof[0]   <= sof_i;
                    r_eof[0]   <= eof_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_sof[i]   <= r_sof[i-1];
                        r_eof[i]   <= r_eof[i-1];
                    end
                end
            end

            assign valid_o = r_valid[DEPTH-1];
            assign sof_o   = r_sof[DEPTH-1];
            assign eof_o   = r_eof[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ul_spectrum_reader.sv
`default_nettype none
// ============================================================================
// Module   : ul_spectrum_reader
// Brief    : Streams an accumulated spectrum buffer out as 16-bit sample pairs.
//            Define UL_FRAME_HEADER_EN to prefix each frame with a 2-word header
//            (header mode expects RD_LAT >= 2).
// Revision : 1.0 - initial release
// ============================================================================
module ul_spectrum_reader
    import ul_spectrum_reader_pkg::*;
#(
    parameter int N_BINS = c_DEFAULT_N_BINS,
    parameter int RD_LAT = c_DEFAULT_RD_LAT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [10:0]               nbins_i,
    output logic                      rd_en_o,
    output logic [$clog2(N_BINS)-1:0] rd_addr_o,
    input  logic [31:0]               rd_data_i,
    output logic [15:0]               y0_o,
    output logic [15:0]               y0z_o,
    output logic                      valid_o,
    output logic                      sof_o,
    output logic                      eof_o,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic [15:0]               frame_cnt_o
);

    localparam int          ADDR_W     = $clog2(N_BINS);
    localparam logic [10:0] c_MAX_BINS = 11'(N_BINS);

    state_t              r_state;
    logic [10:0]         r_nbins;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_busy;
    logic                r_overrun;
    logic [15:0]         r_frame_cnt;
    logic [15:0]         r_y0;
    logic [15:0]         r_y0z;
    logic                r_valid;
    logic                r_sof;
    logic                r_eof;
`ifdef UL_FRAME_HEADER_EN
    logic [7:0]          r_hdr_cnt;
`endif

    logic [ADDR_W-1:0]   w_last_addr;
    logic                w_rd_last;
    logic                w_first_tag;
    logic                w_p_valid;
    logic                w_p_sof;
    logic                w_p_eof;

    assign w_last_addr = ADDR_W'(r_nbins - 11'd1);
    assign w_rd_last   = r_rd_en && (r_rd_addr == w_last_addr);
`ifdef UL_FRAME_HEADER_EN
    assign w_first_tag = 1'b0;
`else
    assign w_first_tag = r_rd_en && (r_rd_addr == '0);
`endif

    ul_rd_pipe #(
        .DEPTH   (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (r_rd_en),
        .sof_i   (w_first_tag),
        .eof_i   (w_rd_last),
        .valid_o (w_p_valid),
        .sof_o   (w_p_sof),
        .eof_o   (w_p_eof)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_nbins     <= 11'd0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_y0        <= 16'd0;
            r_y0z       <= 16'd0;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
`ifdef UL_FRAME_HEADER_EN
            r_hdr_cnt   <= 8'd0;
`endif
        end else begin
            r_valid <= w_p_valid;
            r_sof   <= w_p_sof;
            r_eof   <= w_p_eof;
            r_y0    <= w_p_valid ? rd_data_i[31:16] : 16'd0;
            r_y0z   <= w_p_valid ? rd_data_i[15:0]  : 16'd0;
            if (w_p_valid && w_p_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
`ifdef UL_FRAME_HEADER_EN
            // Header words land in the two output slots just ahead of the first data word.
            if (r_hdr_cnt != 8'd0) begin
                r_hdr_cnt <= r_hdr_cnt - 8'd1;
            end
            if (r_hdr_cnt == 8'd2) begin
                r_valid <= 1'b1;
                r_sof   <= 1'b1;
                r_y0    <= c_SYNC_HI;
                r_y0z   <= c_SYNC_LO;
            end else if (r_hdr_cnt == 8'd1) begin
                r_valid <= 1'b1;
                r_y0    <= r_frame_cnt;
                r_y0z   <= {5'b0, r_nbins};
            end
`endif
            if (r_rd_en) begin
                if (w_rd_last) begin
                    r_rd_en   <= 1'b0;
                    r_rd_addr <= '0;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end

            if (start_i && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_nbins   <= clamp_nbins(nbins_i, c_MAX_BINS);
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
`ifdef UL_FRAME_HEADER_EN
                        r_hdr_cnt <= 8'(RD_LAT);
                        r_state   <= ST_HDR;
`else
                        r_state   <= ST_READ;
`endif
                    end
                end
                ST_HDR: begin
`ifdef UL_FRAME_HEADER_EN
                    if (r_hdr_cnt == 8'd1) begin
                        r_state <= ST_READ;
                    end
`else
                    r_state <= ST_READ;
`endif
                end
                ST_READ: begin
                    if (!r_rd_en || w_rd_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DRAIN;
                end
            endcase

            // eof_o is on the wire this cycle; the frame closes at this edge.
            if (r_eof) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end
    end

    assign rd_en_o     = r_rd_en;
    assign rd_addr_o   = r_rd_addr;
    assign y0_o        = r_y0;
    assign y0z_o       = r_y0z;
    assign valid_o     = r_valid;
    assign sof_o       = r_sof;
    assign eof_o       = r_eof;
    assign busy_o      = r_busy;
    assign overrun_o   = r_overrun;
    assign frame_cnt_o = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/ul_spectrum_reader.md
UL_SPECTRUM_READER -- requirements
Module: ul_spectrum_reader

Interface
- REQ-001 SHALL have parameter N_BINS, default 1024: maximum spectrum bins per frame, a power of two.
- REQ-002 SHALL have parameter RD_LAT, default 2: cycles from rd_en_o to valid rd_data_i.
- REQ-003 SHALL have port clk_i  in  1: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_i  in  1: asynchronous, active-low reset.
- REQ-005 SHALL have port start_i  in  1: one-cycle pulse meaning the accumulated spectrum buffer is ready.
- REQ-006 SHALL have port nbins_i  in  11: bins to read, latched on accepted start_i.
- REQ-007 SHALL have port rd_en_o  out  1: spectrum RAM read strobe.
- REQ-008 SHALL have port rd_addr_o  out  log2(N_BINS): spectrum RAM read address.
- REQ-009 SHALL have port rd_data_i  in  32: spectrum RAM read data.
- REQ-010 SHALL have ports y0_o and y0z_o  out  16 each: output sample pair, matching the processing datapath's two-samples-per-clock format.
- REQ-011 SHALL have port valid_o  out  1: y0_o/y0z_o carry frame data.
- REQ-012 SHALL have ports sof_o and eof_o  out  1 each: first-word and last-word markers, coincident with valid_o.
- REQ-013 SHALL have port busy_o  out  1: a frame is in progress.
- REQ-014 SHALL have port overrun_o  out  1: sticky flag, set when start_i is dropped.
- REQ-015 SHALL have port frame_cnt_o  out  16: count of completed frames, wrapping.

Function
- REQ-016 SHALL implement states IDLE -> (HDR) -> READ -> DRAIN -> IDLE.
- REQ-017 IDLE: start_i SHALL be accepted, nbins_i latched and busy_o set on the next edge.
- REQ-018 A latched nbins of 0 or greater than N_BINS SHALL be clamped to N_BINS.
- REQ-019 READ: rd_en_o SHALL be high for exactly nbins consecutive cycles with rd_addr_o = 0,1,...,nbins-1, then go to DRAIN.
- REQ-020 Each word SHALL appear RD_LAT+1 cycles after its rd_en_o, registered, with y0_o = rd_data_i[31:16] and y0z_o = rd_data_i[15:0]; valid_o stays high contiguously.
- REQ-021 DRAIN SHALL last until the last word has been output; eof_o marks it, frame_cnt_o increments on that cycle, and the block returns to IDLE with busy_o low on the next edge.
- REQ-022 start_i arriving while busy_o is high SHALL be ignored and SHALL set overrun_o; overrun_o clears only on reset.
- REQ-023 start_i in the same cycle as eof_o SHALL be treated as an overrun.
- REQ-024 When valid_o is low, y0_o and y0z_o SHALL be driven to 0.
- REQ-025 frame_cnt_o SHALL wrap from 0xFFFF to 0x0000.

Reset
- REQ-026 Asserting rst_i low SHALL immediately force IDLE and zero every output, including frame_cnt_o and overrun_o.
- REQ-027 Asserting reset mid-frame SHALL abort the frame without asserting eof_o; reads in flight are discarded.

Configuration
- REQ-028 With macro UL_FRAME_HEADER_EN defined, a HDR state SHALL precede READ.
- REQ-029 HDR SHALL emit two valid words, sof_o on the first: word 1 is y0_o = 16'h7FFF, y0z_o = 16'h8000; word 2 is y0_o = frame_cnt_o, y0z_o = {5'b0, latched nbins}.
- REQ-030 Data words SHALL follow the header without a gap; rd_en_o SHALL be pipelined so that no gap appears.
- REQ-031 Without UL_FRAME_HEADER_EN, HDR is absent and sof_o marks the first data word.
- REQ-032 The first rd_en_o SHALL occur the cycle after start_i is accepted in both configurations; with the header enabled, rd_en_o still starts the cycle after acceptance, with data held in the output pipeline as needed.

Structure
- REQ-033 A shared package SHALL hold the state enum, sync words 16'h7FFF/16'h8000, and the default N_BINS and RD_LAT.
- REQ-034 One sub-module, ul_rd_pipe, SHALL be a RD_LAT-deep valid/last shift register aligning sof/eof/valid with the returned data.

Verification
- REQ-035 No header, nbins_i = 4, RAM[a] = {a+1, ~a}, start_i at cycle 10 -> rd_en_o cycles 11-14 at addresses 0-3; valid_o cycles 14-17; sof_o at 14, eof_o at 17; first pair = 0x0001/0xFFFF; frame_cnt_o = 1.
- REQ-036 Header enabled, nbins_i = 2, second frame -> 0x7FFF/0x8000, then 0x0001/0x0002, then 2 data pairs, contiguous valid_o; frame_cnt_o = 2.
- REQ-037 nbins_i = 0 and nbins_i = 1500 -> both read exactly 1024 words, addresses 0..1023 with no wrap; eof_o on word 1024.
- REQ-038 start_i at word 3 of a 16-word frame and again in the eof_o cycle -> both ignored, overrun_o = 1, current frame intact.
- REQ-039 rst_i low at word 500 of 1024 -> all outputs 0 immediately, no eof_o, frame_cnt_o = 0; next start_i -> clean frame from address 0.
